// File: rtl/voice_allocator_if.sv
// Byte-stream input and voice-slot outputs of the voice allocator.
// scan_valid is a one-cycle strobe: a byte is taken on every clock where it is 1, with no backpressure.
interface voice_allocator_if #(
   parameter int NUM_VOICES = 4
);
   logic [7:0]              scan_code;
   logic                    scan_valid;
   logic [NUM_VOICES-1:0]   voice_active;
   logic [2*NUM_VOICES-1:0] voice_row;
   logic [4*NUM_VOICES-1:0] voice_tone;
   logic                    steal;
   logic [1:0]              parser_state;

   modport master (
      output scan_code, scan_valid,
      input  voice_active, voice_row, voice_tone, steal, parser_state
   );

   modport slave (
      input  scan_code, scan_valid,
      output voice_active, voice_row, voice_tone, steal, parser_state
   );
endinterface

// File: rtl/voice_allocator.sv
// PS/2 scan-code parser and polyphonic voice scheduler: held keys occupy
// voice slots, a new note takes the lowest free slot or steals the oldest.
module voice_allocator #(
   parameter int NUM_VOICES = 4
) (
   input logic              clk,
   input logic              reset,
   voice_allocator_if.slave bus
);
   localparam int AW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [AW-1:0] AGE_MAX = AW'(NUM_VOICES - 1);

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXTBRK} state_t;

   state_t        state;
   logic          active [NUM_VOICES];
   logic [1:0]    row    [NUM_VOICES];
   logic [3:0]    tone   [NUM_VOICES];
   logic [AW-1:0] age    [NUM_VOICES];
   logic          steal_q;

   logic [5:0]    key;
   logic          is_prefix;
   logic          hit_found, free_found;
   logic [AW-1:0] hit_idx, free_idx, victim_idx, target_idx, max_age;
   logic          do_make, do_break;

   // Returns {row, tone}; 0 for any code outside the 36 musical keys.
   function automatic logic [5:0] map_key(input logic [7:0] c);
      case (c)
         8'h16: map_key = {2'd1, 4'd1};   8'h1E: map_key = {2'd1, 4'd2};
         8'h26: map_key = {2'd1, 4'd3};   8'h25: map_key = {2'd1, 4'd4};
         8'h2E: map_key = {2'd1, 4'd5};   8'h36: map_key = {2'd1, 4'd6};
         8'h3D: map_key = {2'd1, 4'd7};   8'h3E: map_key = {2'd1, 4'd8};
         8'h46: map_key = {2'd1, 4'd9};   8'h45: map_key = {2'd1, 4'd10};
         8'h4E: map_key = {2'd1, 4'd11};  8'h55: map_key = {2'd1, 4'd12};
         8'h15: map_key = {2'd2, 4'd1};   8'h1D: map_key = {2'd2, 4'd2};
         8'h24: map_key = {2'd2, 4'd3};   8'h2D: map_key = {2'd2, 4'd4};
         8'h2C: map_key = {2'd2, 4'd5};   8'h35: map_key = {2'd2, 4'd6};
         8'h3C: map_key = {2'd2, 4'd7};   8'h43: map_key = {2'd2, 4'd8};
         8'h44: map_key = {2'd2, 4'd9};   8'h4D: map_key = {2'd2, 4'd10};
         8'h54: map_key = {2'd2, 4'd11};  8'h5B: map_key = {2'd2, 4'd12};
         8'h1C: map_key = {2'd3, 4'd1};   8'h1B: map_key = {2'd3, 4'd2};
         8'h23: map_key = {2'd3, 4'd3};   8'h2B: map_key = {2'd3, 4'd4};
         8'h34: map_key = {2'd3, 4'd5};   8'h33: map_key = {2'd3, 4'd6};
         8'h3B: map_key = {2'd3, 4'd7};   8'h42: map_key = {2'd3, 4'd8};
         8'h4B: map_key = {2'd3, 4'd9};   8'h4C: map_key = {2'd3, 4'd10};
         8'h52: map_key = {2'd3, 4'd11};  8'h4A: map_key = {2'd3, 4'd12};
         default: map_key = 6'd0;
      endcase
   endfunction

   // Slot search: held copy of the key, lowest free slot, oldest slot (lowest index on ties).
   always_comb begin
      key        = map_key(bus.scan_code);
      is_prefix  = (bus.scan_code == 8'hF0) || (bus.scan_code == 8'hE0);
      hit_found  = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      victim_idx = '0;
      max_age    = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (active[i] && row[i] == key[5:4] && tone[i] == key[3:0] && !hit_found) begin
            hit_found = 1'b1;
            hit_idx   = AW'(i);
         end
         if (!active[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = AW'(i);
         end
         if (age[i] > max_age) begin
            max_age    = age[i];
            victim_idx = AW'(i);
         end
      end
      target_idx = free_found ? free_idx : victim_idx;
      do_make    = bus.scan_valid && state == IDLE && !is_prefix && key != 6'd0 && !hit_found;
      do_break   = bus.scan_valid && state == BRK && !is_prefix && key != 6'd0 && hit_found;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         steal_q <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            active[i] <= 1'b0;
            row[i]    <= '0;
            tone[i]   <= '0;
            age[i]    <= '0;
         end
      end else begin
         steal_q <= 1'b0;
         if (bus.scan_valid) begin
            case (state)
               IDLE:    state <= (bus.scan_code == 8'hF0) ? BRK :
                                 (bus.scan_code == 8'hE0) ? EXT : IDLE;
               BRK:     state <= (bus.scan_code == 8'hF0) ? BRK :
                                 (bus.scan_code == 8'hE0) ? EXT : IDLE;
               EXT:     state <= (bus.scan_code == 8'hF0) ? EXTBRK : IDLE;
               default: state <= IDLE;
            endcase
         end
         if (do_make) begin
            steal_q <= !free_found;
            for (int i = 0; i < NUM_VOICES; i++) begin
               if (AW'(i) == target_idx) begin
                  active[i] <= 1'b1;
                  row[i]    <= key[5:4];
                  tone[i]   <= key[3:0];
                  age[i]    <= '0;
               end else if (active[i] && age[i] != AGE_MAX) begin
                  age[i] <= age[i] + AW'(1);
               end
            end
         end
         if (do_break) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
               if (AW'(i) == hit_idx) begin
                  active[i] <= 1'b0;
                  row[i]    <= '0;
                  tone[i]   <= '0;
                  age[i]    <= '0;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
      assign bus.voice_active[g]       = active[g];
      assign bus.voice_row[2*g +: 2]   = row[g];
      assign bus.voice_tone[4*g +: 4]  = tone[g];
   end
   assign bus.steal        = steal_q;
   assign bus.parser_state = state;
endmodule
